// File: rtl/iir_pkg.sv
// Shared types and Q16.16 helpers for the time-multiplexed IIR tap sequencer.
package iir_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;

  // 1.0 in Q16.16
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    IDLE,
    FB,
    UPD,
    FF,
    OUT
  } state_e;

  // Bring a 2W Q32.32 accumulator back to a W-bit Q16.16 sample by truncation.
  function automatic logic [W-1:0] trunc_q16(input logic [2*W-1:0] acc);
    return acc[FRAC+W-1:FRAC];
  endfunction

endpackage

// File: rtl/tap_mac.sv
// Shared signed W x W multiplier feeding a wrapping 2W accumulator.
module tap_mac
  import iir_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] acc_q;

  // Signed product via sign-extended operands, then clear / accumulate / hold.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
    prod  = {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_tap_sequencer.sv
// Direct-form-II IIR section: sequences N feedback then N feed-forward taps
// through one shared MAC per sample, with valid/ready sample ports and a
// coefficient config port that is only honoured while idle.
module iir_tap_sequencer
  import iir_pkg::*;
#(
  parameter  int N  = 3,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  output logic          cfg_ack,
  output logic          busy
);

  state_e         state_q, state_d;
  logic [AW-1:0]  k_q, k_d;
  logic [W-1:0]   sample_q;
  logic           cfg_ack_q;

  logic [W-1:0]   a_q      [N];
  logic [W-1:0]   b_q      [N];
  logic [W-1:0]   v_hist_q [N];

  logic           in_hs;
  logic           cfg_hit;
  logic           last_tap;
  logic           mac_clr;
  logic           mac_en;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] acc;

  assign in_hs    = (state_q == IDLE) && in_valid;
  assign cfg_hit  = (state_q == IDLE) && cfg_we && (int'(cfg_addr) < N);
  assign last_tap = (k_q == AW'(N - 1));

  tap_mac u_mac (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .acc_o (acc)
  );

  // Next-state, tap counter and MAC operand selection.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = FB;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      FB: begin
        // Tap 0 multiplies the fresh sample; tap k multiplies v_hist[k-1].
        mac_en = 1'b1;
        mul_a  = a_q[k_q];
        if (k_q == '0) begin
          mul_b = sample_q;
        end else begin
          mul_b = v_hist_q[k_q - AW'(1)];
        end
        if (last_tap) begin
          state_d = UPD;
          k_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      UPD: begin
        mac_clr = 1'b1;
        state_d = FF;
      end
      FF: begin
        mac_en = 1'b1;
        mul_a  = b_q[k_q];
        mul_b  = v_hist_q[k_q];
        if (last_tap) begin
          state_d = OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, tap counter, input sample latch and config ack pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      sample_q  <= '0;
      cfg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cfg_ack_q <= cfg_hit;
      if (in_hs) begin
        sample_q <= in_data;
      end
    end
  end

  // Coefficient banks; a write in the same cycle as a handshake lands before the first FB tap.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this small register file is reset on purpose (a0=b0=1.0 gives a pass-through default); large RAMs normally are not.
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        a_q[i] <= (i == 0) ? ONE : '0;
        b_q[i] <= (i == 0) ? ONE : '0;
      end
    end else if (cfg_hit) begin
      if (cfg_sel) begin
        b_q[cfg_addr] <= cfg_data;
      end else begin
        a_q[cfg_addr] <= cfg_data;
      end
    end
  end

  // Delay-line history: shift in the new intermediate value once per sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        v_hist_q[i] <= '0;
      end
    end else if (state_q == UPD) begin
      for (int i = N - 1; i > 0; i--) begin
        v_hist_q[i] <= v_hist_q[i-1];
      end
      v_hist_q[0] <= trunc_q16(acc);
    end
  end

  // The accumulator is frozen in OUT, so out_data stays stable under backpressure.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_valid ? trunc_q16(acc) : '0;
  assign cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Self-checking bench: per-sample arithmetic model plus latency/handshake
// timing model, compared against the DUT on every falling clock edge.
module tb_iir_tap_sequencer;

  localparam int N   = 3;
  localparam int W   = 32;
  localparam int AW  = $clog2(N);
  localparam int LAT = 2 * N + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_ack;
  logic          busy;

  iir_tap_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ack   (cfg_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_BUSY, P_OUT} phase_e;

  phase_e       m_phase = P_IDLE;
  int           m_cnt   = 0;
  logic         m_ack   = 1'b0;
  logic [W-1:0] m_y     = '0;
  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  logic [W-1:0] mv [N];

  function automatic logic [63:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_ack   = 1'b0;
    m_y     = '0;
    for (int i = 0; i < N; i++) begin
      ma[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
      mb[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
      mv[i] = '0;
    end
  endtask

  // One whole sample of the DF-II section, computed directly from the equations.
  task automatic model_sample(input logic [W-1:0] x_in);
    logic [63:0]  acc;
    logic [W-1:0] x;
    logic [W-1:0] w;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      if (k == 0) x = x_in;
      else        x = mv[k-1];
      acc = acc + mul(ma[k], x);
    end
    w = acc[47:16];
    for (int i = N - 1; i > 0; i--) mv[i] = mv[i-1];
    mv[0] = w;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc + mul(mb[k], mv[k]);
    m_y = acc[47:16];
  endtask

  task automatic model_step();
    if (m_phase == P_IDLE) begin
      m_ack = cfg_we && (int'(cfg_addr) < N);
      if (m_ack) begin
        if (cfg_sel) mb[cfg_addr] = cfg_data;
        else         ma[cfg_addr] = cfg_data;
      end
      if (in_valid) begin
        model_sample(in_data);
        m_phase = P_BUSY;
        m_cnt   = 1;
      end
    end else begin
      m_ack = 1'b0;
      if (m_phase == P_BUSY) begin
        m_cnt++;
        if (m_cnt == LAT) m_phase = P_OUT;
      end else if (out_ready) begin
        m_phase = P_IDLE;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- compare process ----------------
  int           cycle    = 0;
  int           hs_cycle = 0;
  int           lat_last = -1;
  logic         prev_ov  = 1'b0;
  logic [W-1:0] got [$];

  always @(negedge clk) begin
    cycle++;
    check("in_ready",  64'(in_ready),  64'(m_phase == P_IDLE));
    check("busy",      64'(busy),      64'(m_phase != P_IDLE));
    check("out_valid", 64'(out_valid), 64'(m_phase == P_OUT));
    check("cfg_ack",   64'(cfg_ack),   64'(m_ack));
    if (m_phase == P_OUT) check("out_data", 64'(out_data), 64'(m_y));
    else if (!rst)        check("out_data_rst", 64'(out_data), 64'(0));
    if (rst && in_valid && in_ready) hs_cycle = cycle;
    if (rst && out_valid && !prev_ov) lat_last = cycle - hs_cycle;
    prev_ov = out_valid;
    if (rst && out_valid && out_ready) got.push_back(out_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_phase != P_IDLE && n < 200) begin
      tick();
      n++;
    end
    if (m_phase != P_IDLE) timeout("wait_idle");
  endtask

  task automatic wait_out();
    int n = 0;
    while (m_phase != P_OUT && n < 200) begin
      tick();
      n++;
    end
    if (m_phase != P_OUT) timeout("wait_out");
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (!(m_phase == P_BUSY && m_cnt == c) && n < 200) begin
      tick();
      n++;
    end
    if (!(m_phase == P_BUSY && m_cnt == c)) timeout("wait_cnt");
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_idle();
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Drive one config write in the current cycle and check the ack pulse shape.
  task automatic cfg_now(input logic sel, input int addr, input logic [W-1:0] d, input logic exp_ack);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = AW'(addr);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    check("cfg_ack_pulse", 64'(cfg_ack), 64'(exp_ack));
    tick();
    check("cfg_ack_drop", 64'(cfg_ack), 64'(0));
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [W-1:0] d);
    wait_idle();
    cfg_now(sel, addr, d, 1'b1);
  endtask

  function automatic logic [W-1:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  function automatic logic [W-1:0] rand_q();
    logic [W-1:0] r;
    if ($urandom_range(0, 3) == 0) return $urandom;
    r = W'($urandom_range(0, 32'h0003_FFFF));
    return r - 32'h0002_0000;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b1;

    // Pass-through with reset coefficients, plus latency.
    got.delete();
    send(32'h0002_0000);
    wait_idle();
    check("t1_latency", 64'(lat_last), 64'(8));
    check("t1_count", 64'(got.size()), 64'(1));
    check("t1_out", 64'(got_at(0)), 64'(32'h0002_0000));

    // Impulse response with a1 = 0.5.
    do_reset();
    cfg_write(1'b0, 1, 32'h0000_8000);
    got.delete();
    send(32'h0001_0000);
    send(32'h0);
    send(32'h0);
    send(32'h0);
    wait_idle();
    check("t2_y0", 64'(got_at(0)), 64'(32'h0001_0000));
    check("t2_y1", 64'(got_at(1)), 64'(32'h0000_8000));
    check("t2_y2", 64'(got_at(2)), 64'(32'h0000_4000));
    check("t2_y3", 64'(got_at(3)), 64'(32'h0000_2000));

    // Negative coefficient: 3.0 * -0.5.
    do_reset();
    cfg_write(1'b1, 0, 32'hFFFF_8000);
    got.delete();
    send(32'h0003_0000);
    wait_idle();
    check("t3_neg", 64'(got_at(0)), 64'(32'hFFFE_8000));

    // Backpressure: output held for 5 cycles.
    do_reset();
    out_ready = 1'b0;
    got.delete();
    send(32'h0005_0000);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_data", 64'(out_data), 64'(32'h0005_0000));
      check("t4_hold_valid", 64'(out_valid), 64'(1));
      check("t4_hold_in_ready", 64'(in_ready), 64'(0));
      check("t4_hold_busy", 64'(busy), 64'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t4_after_valid", 64'(out_valid), 64'(0));
    check("t4_after_in_ready", 64'(in_ready), 64'(1));
    check("t4_count", 64'(got.size()), 64'(1));
    check("t4_out", 64'(got_at(0)), 64'(32'h0005_0000));

    // Config while busy is dropped; the same write in idle takes effect.
    do_reset();
    got.delete();
    send(32'h0001_0000);
    wait_cnt(N + 3);
    cfg_now(1'b1, 0, 32'h0002_0000, 1'b0);
    wait_idle();
    check("t5_busy_write", 64'(got_at(0)), 64'(32'h0001_0000));
    cfg_write(1'b1, 0, 32'h0002_0000);
    send(32'h0001_0000);
    wait_idle();
    check("t5_idle_write", 64'(got_at(1)), 64'(32'h0002_0000));

    // Out-of-range address is ignored.
    cfg_now(1'b1, 3, 32'h0004_0000, 1'b0);

    // Reset in the middle of the feed-forward phase.
    do_reset();
    cfg_write(1'b0, 1, 32'h0000_8000);
    got.delete();
    send(32'h0001_0000);
    send(32'h0);
    wait_cnt(N + 3);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    tick();
    rst = 1'b1;
    check("t6_partial_count", 64'(got.size()), 64'(1));
    cfg_write(1'b0, 1, 32'h0000_8000);
    got.delete();
    send(32'h0001_0000);
    send(32'h0);
    wait_idle();
    check("t6_y0", 64'(got_at(0)), 64'(32'h0001_0000));
    check("t6_y1", 64'(got_at(1)), 64'(32'h0000_8000));

    // Randomised traffic, config, backpressure and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 599) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = rand_q();
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_sel   = 1'($urandom_range(0, 1));
      cfg_addr  = AW'($urandom_range(0, (1 << AW) - 1));
      cfg_data  = rand_q();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_tap_sequencer.md
Name: iir_tap_sequencer

Overview:
Time-multiplexed controller for a direct-form-II IIR section in Q16.16 fixed point. One shared 32x32 multiplier and a 64-bit accumulator are sequenced over N feedback taps and then N feed-forward taps per sample. Samples enter and leave through valid/ready handshakes. The block also owns the coefficient registers, which are reprogrammed through a config port.

Parameters:
N, 3, taps per direction (a0..a(N-1), b0..b(N-1)); legal range 2..8
W, 32, sample/coefficient width, Q16.16 (FRAC=16 fixed)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
in_data  in  W  input sample, Q16.16 signed
in_valid  in  1  input sample valid
in_ready  out  1  high only in IDLE
out_data  out  W  output sample, Q16.16 signed
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts
cfg_we  in  1  coefficient write strobe
cfg_sel  in  1  0 = a bank, 1 = b bank
cfg_addr  in  $clog2(N)  tap index
cfg_data  in  W  coefficient, Q16.16 signed
cfg_ack  out  1  one-cycle pulse when a write is applied
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset rst is asynchronous, active-low. While rst=0, all of the following hold:
  - state=IDLE; accumulator, sample latch and history v_hist[0..N-1] are 0.
  - out_data=0, out_valid=0, cfg_ack=0, busy=0, in_ready=1 (IDLE).
  - Coefficients reset to a0=b0=0x00010000 and all other taps to 0.
- Arithmetic:
  - Products are signed W x W -> 2W and are summed in a 2W accumulator with wrap, no saturation.
  - Results are truncated to bits [47:16].
  - Feedback coefficients are stored with sign already applied; the accumulator only adds.
- States:
  - IDLE: on in_valid & in_ready (cycle T), latch in_data, clear acc, k=0 -> FB.
  - FB (cycles T+1..T+N): acc += a_k * x_k, where x_0 = latched sample and x_k = v_hist[k-1] for k>=1. After k=N-1 -> UPD.
  - UPD (T+N+1): v_new = acc[47:16]; shift v_hist[i] <= v_hist[i-1], v_hist[0] <= v_new; clear acc -> FF.
  - FF (T+N+2..T+2N+1): acc += b_k * v_hist[k]. After k=N-1 -> OUT.
  - OUT (from T+2N+2): out_data = acc[47:16], out_valid=1. Hold both until out_ready; on out_valid & out_ready -> IDLE with out_valid=0 the next cycle.
- Timing:
  - Input-to-output latency is 2N+2 cycles (8 for N=3). Throughput is at most one sample per 2N+3 cycles.
  - in_ready is combinationally (state==IDLE); there is no same-cycle output-accept/input-accept overlap.
- Config port:
  - A write is applied only when cfg_we=1 and state==IDLE, with cfg_ack pulsed the following cycle.
  - If a write and an input handshake occur in the same IDLE cycle, the write is applied first and the sample uses the new coefficient.
  - When busy, writes are dropped with no ack.
  - cfg_addr >= N is ignored with no ack.
- Reset mid-operation: any state aborts immediately to the reset values above. A partial sample is never emitted, and history is cleared.
- out_data is stable while out_valid=1 and out_ready=0.

Decomposition:
- Package iir_pkg: W, FRAC=16, the state enum (IDLE, FB, UPD, FF, OUT), the Q16.16 constant ONE=0x00010000, and a trunc_q16 function selecting [47:16].
- Sub-module tap_mac: registered signed multiply-accumulate with clr/en inputs and a 2W acc output.
- FSM, tap counter, coefficient banks and history stay in iir_tap_sequencer.

Test Plan:
- Reset defaults, then in_data=0x00020000, out_ready=1 -> out_valid exactly 8 cycles after the handshake, out_data=0x00020000.
- Program a1=0x00008000 (0.5), b0=1.0. Impulse 0x00010000 then zeros -> outputs 0x00010000, 0x00008000, 0x00004000, 0x00002000.
- Negative/truncation: a0=1.0, b0=0xFFFF8000 (-0.5), in=0x00030000 -> out=0xFFFE8000 (-1.5).
- Backpressure: hold out_ready=0 for 5 cycles at OUT -> out_data stable, in_ready=0, busy=1. Release -> one transfer, then IDLE.
- Config while busy: cfg_we during FF -> no cfg_ack, coefficient unchanged. Same write in IDLE -> cfg_ack one cycle later, and the next sample reflects it.
- Reset mid-operation: drop rst during FF of the second impulse-response sample -> out_valid=0 immediately. Next impulse reproduces the first-sample response with a clean history.
